// File: rtl/wb_mem_copy_pkg.sv
// Shared types for the Wishbone copy/fill sequencer: FSM encoding and mode constants.
package wb_mem_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_FIN     = 3'd5
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/wb_mem_copy_if.sv
// Classic single-request Wishbone bus between the copy engine and one RAM port.
interface wb_mem_copy_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4
) ();

    logic [ADDR_WIDTH-1:0]   m_adr_o;
    logic [DATA_WIDTH-1:0]   m_dat_i;
    logic [DATA_WIDTH-1:0]   m_dat_o;
    logic                    m_we_o;
    logic [SELECT_WIDTH-1:0] m_sel_o;
    logic                    m_stb_o;
    logic                    m_cyc_o;
    logic                    m_ack_i;
    logic                    m_err_i;

    modport master (
        output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
        input  m_dat_i, m_ack_i, m_err_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
        output m_dat_i, m_ack_i, m_err_i
    );

endinterface

// File: rtl/wb_mem_copy.sv
// Wishbone master that copies (src->dst) or fills (constant->dst) a block of words,
// one access in flight at a time, with a start/busy/done/error control interface.
module wb_mem_copy
    import wb_mem_copy_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [DATA_WIDTH-1:0]  fill_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    wb_mem_copy_if.master          m
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(SELECT_WIDTH);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]  src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0]  dst_ptr_q, dst_ptr_d;
    logic [COUNT_WIDTH-1:0] remain_q, remain_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [DATA_WIDTH-1:0]  dat_q, dat_d;
    logic                   we_q, we_d;
    logic                   stb_q, stb_d;

    // Strobe is only raised on the REQ->WAIT edge, so each REQ state doubles as
    // the mandatory idle cycle after the previous ack.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        remain_d  = remain_q;
        data_d    = data_q;
        error_d   = error_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        stb_d     = stb_q;
        done_d    = (state_q == S_FIN);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (count == '0) begin
                        state_d = S_FIN;
                    end else begin
                        mode_d    = mode;
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        remain_d  = count;
                        // Fill value rides in the data register; a copy overwrites it on its first read.
                        data_d    = fill_data;
                        state_d   = (mode == MODE_FILL) ? S_WR_REQ : S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                adr_d   = src_ptr_q;
                we_d    = 1'b0;
                stb_d   = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (m.m_err_i) begin
                    stb_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else if (m.m_ack_i) begin
                    data_d  = m.m_dat_i;
                    stb_d   = 1'b0;
                    state_d = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                adr_d   = dst_ptr_q;
                we_d    = 1'b1;
                dat_d   = data_q;
                stb_d   = 1'b1;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (m.m_err_i) begin
                    stb_d   = 1'b0;
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else if (m.m_ack_i) begin
                    stb_d     = 1'b0;
                    dst_ptr_d = dst_ptr_q + STRIDE;
                    if (mode_q == MODE_COPY) src_ptr_d = src_ptr_q + STRIDE;
                    remain_d  = remain_q - 1'b1;
                    if (remain_q == COUNT_WIDTH'(1))  state_d = S_FIN;
                    else if (mode_q == MODE_FILL)     state_d = S_WR_REQ;
                    else                              state_d = S_RD_REQ;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
                 (state_d == S_WR_REQ) || (state_d == S_WR_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_COPY;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            remain_q  <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            remain_q  <= remain_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            stb_q     <= stb_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign m.m_adr_o = adr_q;
    assign m.m_dat_o = dat_q;
    assign m.m_we_o  = we_q;
    assign m.m_stb_o = stb_q;
    assign m.m_cyc_o = stb_q;
    assign m.m_sel_o = {SELECT_WIDTH{stb_q}};

endmodule

// File: tb/tb_wb_mem_copy.sv
// Directed bench for wb_mem_copy: table of transfers against a zero-wait RAM model,
// plus hand-written sequences for reset, start-while-busy and reset mid-transfer.
module tb_wb_mem_copy;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] count = '0;
    logic [31:0] fill_data = '0;
    logic        busy, done, error;

    wb_mem_copy_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4)) bus ();

    wb_mem_copy #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .count(count), .fill_data(fill_data),
        .busy(busy), .done(done), .error(error), .m(bus)
    );

    always #5 clk = ~clk;

    // RAM model: acks in the same cycle it sees stb; can stall or inject an error on the Nth read.
    logic [31:0] mem [1024];
    logic        clr = 1'b0;
    logic        stall = 1'b0;
    int          err_on_rd = 0;
    int          rd_cnt = 0, wr_cnt = 0, stb_cyc = 0, busy_cyc = 0, gap_viol = 0;
    logic        prev_ack = 1'b0;

    assign bus.m_ack_i = bus.m_stb_o & bus.m_cyc_o & ~stall;
    assign bus.m_err_i = bus.m_stb_o & ~bus.m_we_o & (err_on_rd != 0) & (rd_cnt + 1 == err_on_rd);
    assign bus.m_dat_i = mem[bus.m_adr_o[11:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[64] <= 32'h11; mem[65] <= 32'h22; mem[66] <= 32'h33; mem[67] <= 32'h44;
            rd_cnt <= 0; wr_cnt <= 0; stb_cyc <= 0; busy_cyc <= 0;
        end else begin
            if (bus.m_stb_o) stb_cyc <= stb_cyc + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (bus.m_stb_o && bus.m_ack_i && !bus.m_err_i) begin
                if (bus.m_we_o) begin
                    mem[bus.m_adr_o[11:2]] <= bus.m_dat_o;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end
        end
        if (prev_ack && bus.m_stb_o) gap_viol <= gap_viol + 1;
        prev_ack <= bus.m_stb_o & bus.m_ack_i;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] src, dst;
        logic [15:0] cnt;
        logic [31:0] fill;
        int          err_rd;
        int          exp_wr, exp_lat, exp_stb, exp_busy;
        logic        exp_err;
        logic [31:0] exp_first, exp_last;
    } vec_t;

    vec_t vecs [6];

    task automatic clear_model();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    // Drive start for one cycle; returns at mid-cycle of the first cycle after acceptance.
    task automatic pulse_start(input logic md, input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] n, input logic [31:0] f);
        @(negedge clk);
        start = 1'b1; mode = md; src_addr = s; dst_addr = d; count = n; fill_data = f;
        @(negedge clk);
        start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; count = '0; fill_data = '0;
    endtask

    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        string tag;
        tag = $sformatf("v%0d", idx);
        clear_model();
        err_on_rd = v.err_rd;
        pulse_start(v.mode, v.src, v.dst, v.cnt, v.fill);
        wait_done(1, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        chk({tag, "_error"}, 64'(error), 64'(v.exp_err));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'(0));
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done), 64'(0));
        chk({tag, "_writes"}, 64'(wr_cnt), 64'(v.exp_wr));
        chk({tag, "_stb_cycles"}, 64'(stb_cyc), 64'(v.exp_stb));
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(v.exp_busy));
        if (v.exp_wr > 0) begin
            chk({tag, "_first_word"}, 64'(mem[v.dst[11:2]]), 64'(v.exp_first));
            chk({tag, "_last_word"}, 64'(mem[10'(v.dst[11:2] + 10'(v.exp_wr - 1))]), 64'(v.exp_last));
        end
        chk({tag, "_untouched"}, 64'(mem[10'(v.dst[11:2] + 10'(v.exp_wr))]), 64'(0));
        err_on_rd = 0;
    endtask

    initial begin
        int lat;
        int n;

        //          mode src        dst        cnt fill          err wr lat stb bsy err first         last
        vecs[0] = '{1'b0, 32'h100, 32'h200, 16'd4, 32'h0,        0, 4, 18, 8, 16, 1'b0, 32'h11,       32'h44};
        vecs[1] = '{1'b1, 32'h0,   32'h40,  16'd3, 32'hDEADBEEF, 0, 3, 8,  3, 6,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 32'h100, 32'h200, 16'd0, 32'h0,        0, 0, 2,  0, 0,  1'b0, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 32'h100, 32'h200, 16'd4, 32'h0,        2, 1, 8,  3, 6,  1'b1, 32'h11,       32'h11};
        vecs[4] = '{1'b0, 32'h104, 32'h300, 16'd2, 32'h0,        0, 2, 10, 4, 8,  1'b0, 32'h22,       32'h33};
        vecs[5] = '{1'b1, 32'h0,   32'h3F8, 16'd1, 32'h12345678, 0, 1, 4,  1, 2,  1'b0, 32'h12345678, 32'h12345678};

        #12;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_stb_cyc", 64'({bus.m_stb_o, bus.m_cyc_o, bus.m_we_o}), 64'(0));
        chk("reset_adr_dat_sel", 64'({bus.m_adr_o, bus.m_sel_o}) | 64'(bus.m_dat_o), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // start pulsed mid-copy with different parameters must not disturb the transfer
        clear_model();
        pulse_start(1'b0, 32'h100, 32'h200, 16'd4, 32'h0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        start = 1'b1; mode = 1'b1; src_addr = 32'h0; dst_addr = 32'h500; count = 16'd9; fill_data = 32'hBAD;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat);
        chk("busy_start_latency", 64'(lat), 64'(18));
        chk("busy_start_writes", 64'(wr_cnt), 64'(4));
        chk("busy_start_word0", 64'(mem[128]), 64'(32'h11));
        chk("busy_start_word3", 64'(mem[131]), 64'(32'h44));
        chk("busy_start_no_fill", 64'(mem[320]), 64'(0));
        @(negedge clk);

        // reset asserted while the second fill write is stalled in WR_WAIT
        clear_model();
        pulse_start(1'b1, 32'h0, 32'h40, 16'd3, 32'hCAFEF00D);
        n = 0;
        while (wr_cnt != 1 && n < 50) begin @(negedge clk); n++; end
        stall = 1'b1;
        n = 0;
        while (!(bus.m_stb_o && bus.m_we_o) && n < 50) begin @(negedge clk); n++; end
        chk("rst_mid_reached_wait", 64'(bus.m_stb_o && bus.m_we_o && busy), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({bus.m_stb_o, bus.m_cyc_o, busy, done}), 64'(0));
        chk("rst_mid_writes", 64'(wr_cnt), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_idle", 64'({bus.m_stb_o, busy, done, error}), 64'(0));
        run_vec(6, vecs[1]);

        chk("stb_gap_after_ack", 64'(gap_viol), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
